// File: rtl/caq_tape_player.sv
// caq_tape_player: replays a CAQ image from tape RAM as the serial cassette
// waveform. Each bit is one square cycle (high half then low half). A start
// '0' bit comes first, then data MSB first, then STOP_BITS '1' cycles.
// Optional motor gating is enabled by defining CAQ_TAPE_MOTOR_EN.
module caq_tape_player #(
  parameter int AW        = 16,
  parameter int HALF1     = 1,
  parameter int HALF0     = 2,
  parameter int STOP_BITS = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_tape,
  input  logic          loaded,
  input  logic [AW-1:0] length,
  input  logic          pause,
  input  logic          rewind,
`ifdef CAQ_TAPE_MOTOR_EN
  input  logic          motor,
`endif
  input  logic [7:0]    data,
  output logic [AW-1:0] addr,
  output logic          req,
  output logic          out,
  output logic          done
);

  localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int TW   = $clog2(HMAX) + 1;
  localparam logic [TW-1:0] H1_LAST = TW'(HALF1 - 1);
  localparam logic [TW-1:0] H0_LAST = TW'(HALF0 - 1);
  localparam logic [1:0]    SB      = 2'(STOP_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_BIT,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] len_q, len_d;
  logic [8:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          phase_q, phase_d;
  logic [1:0]    stop_q, stop_d;

  logic          freeze;
  logic          tick;
  logic [TW-1:0] half_last;
  logic [AW-1:0] addr_inc;

  // Freeze condition gates tick-driven progress only; FETCH/LOAD still run
`ifdef CAQ_TAPE_MOTOR_EN
  assign freeze = pause | ~motor;
`else
  assign freeze = pause;
`endif

  assign tick      = ce_tape & ~freeze;
  assign half_last = ((state_q == ST_STOP) || shreg_q[8]) ? H1_LAST : H0_LAST;
  assign addr_inc  = addr_q + AW'(1);

  // Next-state, datapath updates and outputs; every value defaults to hold
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tick_d    = tick_q;
    phase_d   = phase_q;
    stop_d    = stop_q;
    req       = 1'b0;
    out       = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_FETCH: req = 1'b1;
      ST_LOAD:  req = 1'b1;
      ST_BIT:   begin req = 1'b1; out = phase_q; end
      ST_STOP:  begin req = 1'b1; out = phase_q; end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase

    if (rewind) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else if (loaded) begin
      // An empty image finishes at once; otherwise (re)start at byte 0
      len_d   = length;
      addr_d  = '0;
      state_d = (length == '0) ? ST_DONE : ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          shreg_d   = {1'b0, data};
          bit_cnt_d = 4'd9;
          tick_d    = '0;
          phase_d   = 1'b1;
          state_d   = ST_BIT;
        end
        ST_BIT: begin
          if (tick) begin
            if (tick_q == half_last) begin
              tick_d = '0;
              if (phase_q) begin
                phase_d = 1'b0;
              end else begin
                phase_d = 1'b1;
                if (bit_cnt_q == 4'd1) begin
                  stop_d  = SB;
                  state_d = ST_STOP;
                end else begin
                  bit_cnt_d = bit_cnt_q - 4'd1;
                  shreg_d   = {shreg_q[7:0], 1'b0};
                end
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_q == half_last) begin
              tick_d = '0;
              if (phase_q) begin
                phase_d = 1'b0;
              end else if (stop_q == 2'd1) begin
                addr_d  = addr_inc;
                state_d = (addr_inc == len_q) ? ST_DONE : ST_FETCH;
              end else begin
                stop_d  = stop_q - 2'd1;
                phase_d = 1'b1;
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      phase_q   <= 1'b0;
      stop_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      stop_q    <= stop_d;
    end
  end

  assign addr = addr_q;

endmodule
